// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: issues operands to an external multiplier or
// divider, stalls the pipeline until done, and writes HI/LO once. Optional: MULDIV_DIV0_FAST_EN.
module muldiv_ctrl #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_adv,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;

  localparam logic [2:0] CntLoad = 3'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d;

  logic req, is_mul, is_sgn, div0_fast, we, annul;
  logic in_mul, in_div;

  assign req = op_valid && (op != 4'b0000);

  // op is {mult, multu, div, divu}; the highest set bit wins.
  assign is_mul = op[3] | op[2];
  assign is_sgn = op[3] | (~op[2] & op[1]);

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = ~is_mul && (src_b == 32'h0);
`else
  assign div0_fast = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    we      = 1'b0;
    annul   = 1'b0;
    if (flush) begin
      state_d = StIdle;
      annul   = (state_q == StDivWait);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            a_d   = src_a;
            b_d   = src_b;
            sgn_d = is_sgn;
            if (is_mul) begin
              state_d = StMulWait;
              cnt_d   = CntLoad;
            end else if (div0_fast) begin
              hi_d    = src_a;
              lo_d    = 32'hFFFF_FFFF;
              state_d = StDone;
            end else begin
              state_d = StDivWait;
            end
          end
        end
        StMulWait: begin
          if (cnt_q == 3'd0) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StDivWait: begin
          if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = StDone;
          end
        end
        StDone: begin
          // Ignore op_valid here: EX still holds the finished instruction until ex_adv.
          if (ex_adv) begin
            we      = 1'b1;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Every combinational output is forced low while reset is held.
  assign in_mul = resetn && (state_q == StMulWait);
  assign in_div = resetn && (state_q == StDivWait);

  assign stallreq = resetn && ((state_q == StIdle && req && !flush) ||
                               state_q == StMulWait || state_q == StDivWait);

  assign hi_we = resetn && we;
  assign lo_we = resetn && we;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

  assign mul_signed = in_mul && sgn_q;
  assign mul_ina    = in_mul ? a_q : 32'h0;
  assign mul_inb    = in_mul ? b_q : 32'h0;

  assign div_start   = in_div;
  assign div_signed  = in_div && sgn_q;
  assign div_opdata1 = in_div ? a_q : 32'h0;
  assign div_opdata2 = in_div ? b_q : 32'h0;
  assign div_annul   = resetn && annul;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: models a 2-cycle multiplier and a variable-latency
// divider, and scoreboards every HI/LO write against queued expectations.
module tb_muldiv_ctrl;

  localparam int unsigned ML = 2;

  logic        clk = 1'b0;
  logic        resetn, op_valid, flush, ex_adv, adv_en;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int div_cnt  = 0;
  int div_lat  = 5;
  logic [31:0] last_hi, last_lo;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LATENCY(ML)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .ex_adv      (ex_adv),
    .stallreq    (stallreq),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .mul_signed  (mul_signed),
    .mul_ina     (mul_ina),
    .mul_inb     (mul_inb),
    .mul_result  (mul_result),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_annul   (div_annul),
    .div_opdata1 (div_opdata1),
    .div_opdata2 (div_opdata2),
    .div_ready   (div_ready),
    .div_result  (div_result)
  );

  // EX advances whenever the bench allows it and the controller is not stalling.
  assign ex_adv = adv_en & ~stallreq;

  // One pipeline register: result valid ML=2 cycles after operands appear.
  always_ff @(posedge clk) begin
    if (mul_signed) mul_result <= {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
    else            mul_result <= {32'h0, mul_ina} * {32'h0, mul_inb};
  end

  always_ff @(posedge clk) div_cnt <= (div_start && !div_ready) ? div_cnt + 1 : 0;
  assign div_ready = div_start && (div_cnt == div_lat - 1);

  logic signed [31:0] sq, sr;
  always_comb begin
    sq = '0;
    sr = '0;
    div_result = '0;
    if (div_opdata2 == 32'h0) begin
      div_result = {div_opdata1, 32'hFFFF_FFFF};
    end else if (div_signed) begin
      sq = $signed(div_opdata1) / $signed(div_opdata2);
      sr = $signed(div_opdata1) % $signed(div_opdata2);
      div_result = {sr, sq};
    end else begin
      div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hi_we || lo_we) begin
      wr_count <= wr_count + 1;
      check_eq("we_pair", {63'h0, hi_we}, {63'h0, lo_we});
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {62'h0, hi_we, lo_we}, 64'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("hi_o", {32'h0, hi_o}, {32'h0, mon_exp[63:32]});
        check_eq("lo_o", {32'h0, lo_o}, {32'h0, mon_exp[31:0]});
      end
    end
  end

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int exp_stall, input int exp_ds,
                       input logic [31:0] eh, input logic [31:0] el);
    int n, nds, w0;
    exp_q.push_back({eh, el});
    w0 = wr_count;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; adv_en = (hold == 0);
    n = 0; nds = 0;
    @(negedge clk);
    while (stallreq && n < 200) begin
      n++;
      if (div_start) nds++;
      @(negedge clk);
    end
    check_eq("stall_cycles", n, exp_stall);
    check_eq("div_start_cycles", nds, exp_ds);
    for (int h = 0; h < hold; h++) begin
      check_eq("we_while_held", {62'h0, hi_we, lo_we}, 64'h0);
      check_eq("stall_while_held", {63'h0, stallreq}, 64'h0);
      @(posedge clk); #1;
      if (h == hold - 1) adv_en = 1'b1;
      @(negedge clk);
    end
    check_eq("we_on_adv", {62'h0, hi_we, lo_we}, 64'h3);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'b0; adv_en = 1'b0;
    @(negedge clk);
    check_eq("we_after", {62'h0, hi_we, lo_we}, 64'h0);
    check_eq("stall_after", {63'h0, stallreq}, 64'h0);
    check_eq("one_write", wr_count - w0, 1);
    check_eq("hi_hold", {32'h0, hi_o}, {32'h0, eh});
    last_hi = eh;
    last_lo = el;
  endtask

  // Flush in the at-th wait cycle; HI/LO must stay as the previous operation left them.
  task automatic flush_op(input logic [3:0] o, input int lat, input int at);
    div_lat = lat;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = 32'd100; src_b = 32'd7; adv_en = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= at; k++) begin
      @(posedge clk); #1;
      if (k == at) flush = 1'b1;
      @(negedge clk);
    end
    check_eq("annul_on_flush", {63'h0, div_annul}, {63'h0, ~o[3] & ~o[2]});
    check_eq("we_on_flush", {62'h0, hi_we, lo_we}, 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 4'b0;
    @(negedge clk);
    check_eq("stall_post_flush", {63'h0, stallreq}, 64'h0);
    check_eq("dstart_post_flush", {63'h0, div_start}, 64'h0);
    check_eq("annul_post_flush", {63'h0, div_annul}, 64'h0);
    repeat (3) @(negedge clk);
    check_eq("hi_post_flush", {hi_o, lo_o}, {last_hi, last_lo});
    div_lat = 5;
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op = 4'b0; src_a = '0; src_b = '0;
    flush = 1'b0; adv_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {63'h0, stallreq}, 64'h0);
    check_eq("rst_hilo", {hi_o, lo_o}, 64'h0);
    check_eq("rst_we", {62'h0, hi_we, lo_we}, 64'h0);
    check_eq("rst_div", {31'h0, div_start, div_opdata1}, 64'h0);
    check_eq("rst_mul", {mul_ina, mul_inb}, 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    do_op(4'b1000, 32'hFFFF_FFFD, 32'd5, 0, 3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    div_lat = 33;
    do_op(4'b0001, 32'd100, 32'd7, 0, 34, 33, 32'd2, 32'd14);
    div_lat = 5;
    do_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 3, 6, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(4'b0110, 32'd3, 32'd4, 0, 3, 0, 32'd0, 32'd12);
    do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 0, 32'd0, 32'd1);

    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("op_zero_stall", {63'h0, stallreq}, 64'h0);
    end
    op_valid = 1'b0;

    flush_op(4'b0010, 40, 10);
    flush_op(4'b0010, 3, 3);
    flush_op(4'b1000, 5, ML);

`ifdef MULDIV_DIV0_FAST_EN
    do_op(4'b0010, 32'd9, 32'd0, 0, 1, 0, 32'd9, 32'hFFFF_FFFF);
`else
    do_op(4'b0010, 32'd9, 32'd0, 0, 6, 5, 32'd9, 32'hFFFF_FFFF);
`endif

    // Reset during MUL_WAIT discards the operation.
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'b1000; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; op_valid = 1'b0; op = 4'b0;
    @(negedge clk);
    check_eq("mrst_stall", {63'h0, stallreq}, 64'h0);
    check_eq("mrst_hilo", {hi_o, lo_o}, 64'h0);
    check_eq("mrst_mul", {31'h0, mul_signed, mul_ina}, 64'h0);
    last_hi = 32'h0;
    last_lo = 32'h0;

    // Reset during DIV_WAIT with a concurrent flush must not annul.
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'b0001; src_a = 32'd50; src_b = 32'd3; div_lat = 20;
    @(posedge clk); #1;
    resetn = 1'b0; flush = 1'b1;
    @(negedge clk);
    check_eq("drst_annul", {63'h0, div_annul}, 64'h0);
    check_eq("drst_dstart", {63'h0, div_start}, 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 4'b0; div_lat = 5;
    @(negedge clk);
    check_eq("drst_stall", {63'h0, stallreq}, 64'h0);

    do_op(4'b0100, 32'hFFFF_FFFF, 32'd2, 0, 3, 0, 32'd1, 32'hFFFF_FFFE);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
